// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, error codes and datapath selects.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_IMEM = 2'b01;
    localparam logic [1:0] ERR_DRAM = 2'b10;
    localparam logic [1:0] ERR_ILL  = 2'b11;

    localparam logic [1:0] NPC_PC_4    = 2'd0;
    localparam logic [1:0] NPC_PC_IMM  = 2'd1;
    localparam logic [1:0] NPC_RD1_IMM = 2'd2;

    localparam logic [2:0] EXT_I = 3'd0;
    localparam logic [2:0] EXT_S = 3'd1;
    localparam logic [2:0] EXT_B = 3'd2;
    localparam logic [2:0] EXT_U = 3'd3;
    localparam logic [2:0] EXT_J = 3'd4;

    localparam logic [1:0] WD_ALUC = 2'd0;
    localparam logic [1:0] WD_DRAM = 2'd1;
    localparam logic [1:0] WD_PC4  = 2'd2;
    localparam logic [1:0] WD_EXT  = 2'd3;

    localparam logic ALUB_RS2 = 1'b0;
    localparam logic ALUB_EXT = 1'b1;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;
    localparam logic WRITE   = 1'b1;
    localparam logic READ    = 1'b0;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    // Shared by R and I forms; the funct7 alternate bit only selects SUB for R.
    function automatic logic [3:0] alu_from_funct(input logic [2:0] f3, input logic alt, input logic is_r);
        case (f3)
            3'b000:  return (is_r && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/mctrl_decode.sv
// Combinational instruction decode: inst plus registered ALU flags -> datapath selects.
module mctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [31:0] inst,
    input  logic        flag_zero,
    input  logic        flag_sgn,
    output logic [1:0]  npc_op,
    output logic [2:0]  sext_op,
    output logic [1:0]  wd_sel,
    output logic        alub_sel,
    output logic [3:0]  alu_op,
    output logic        legal,
    output logic        is_mem,
    output logic        is_store,
    output logic        rf_wr
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alt;
    logic       taken;
    logic       unused_fields;

    assign opcode        = inst[6:0];
    assign funct3        = inst[14:12];
    assign alt           = inst[30];
    assign unused_fields = ^{inst[31], inst[29:15], inst[11:7]};

    always_comb begin
        case (funct3)
            3'b000:  taken = flag_zero;
            3'b001:  taken = !flag_zero;
            3'b100:  taken = flag_sgn;
            3'b101:  taken = !flag_sgn;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        npc_op   = NPC_PC_4;
        sext_op  = EXT_I;
        wd_sel   = WD_ALUC;
        alub_sel = ALUB_EXT;
        alu_op   = ALU_ADD;
        legal    = 1'b1;
        is_mem   = 1'b0;
        is_store = 1'b0;
        rf_wr    = 1'b1;
        case (opcode)
            OP_R: begin
                alub_sel = ALUB_RS2;
                alu_op   = alu_from_funct(funct3, alt, 1'b1);
            end
            OP_I: alu_op = alu_from_funct(funct3, alt, 1'b0);
            OP_LOAD: begin
                wd_sel = WD_DRAM;
                is_mem = 1'b1;
            end
            OP_S: begin
                sext_op  = EXT_S;
                is_mem   = 1'b1;
                is_store = 1'b1;
                rf_wr    = 1'b0;
            end
            OP_B: begin
                sext_op  = EXT_B;
                alub_sel = ALUB_RS2;
                alu_op   = ALU_SUB;
                rf_wr    = 1'b0;
                npc_op   = taken ? NPC_PC_IMM : NPC_PC_4;
            end
            OP_LUI: begin
                sext_op = EXT_U;
                wd_sel  = WD_EXT;
            end
            OP_JAL: begin
                sext_op = EXT_J;
                wd_sel  = WD_PC4;
                npc_op  = NPC_PC_IMM;
            end
            OP_JALR: begin
                wd_sel = WD_PC4;
                npc_op = NPC_RD1_IMM;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I-subset controller: FSM, memory wait counter, flag register and strobes.
// Build option: define MCTRL_ILL_INST_EN to halt with err_code 11 on unsupported opcodes.
//
// state  | meaning
// FETCH  | imem request until ack (loads IR) or timeout
// DECODE | one cycle, selects settle from the IR
// EXEC   | one cycle, ALU flags captured at its end
// MEM    | dram request until ack or timeout
// WB     | PC load and register write
// HALT   | error stop, left only by reset
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    input  logic        zero,
    input  logic        sgn,
    input  logic        imem_ack,
    input  logic        dram_ack,
    output logic        imem_req,
    output logic        dram_req,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  npc_op,
    output logic [2:0]  sext_op,
    output logic [1:0]  wd_sel,
    output logic        alub_sel,
    output logic [3:0]  alu_op,
    output logic        rf_we,
    output logic        dram_we,
    output logic [2:0]  state,
    output logic        halt,
    output logic [1:0]  err_code
);

    state_t     cur_state, nxt_state;
    logic [7:0] wait_cnt;
    logic       wait_last;
    logic       flag_zero, flag_sgn;
    logic [1:0] err_q, err_nxt;
    logic       legal, is_mem, is_store, rf_wr;
    logic       imem_req_c, dram_req_c, ir_we_c, pc_we_c, rf_we_c, dram_we_c;

    mctrl_decode u_decode (
        .inst      (inst),
        .flag_zero (flag_zero),
        .flag_sgn  (flag_sgn),
        .npc_op    (npc_op),
        .sext_op   (sext_op),
        .wd_sel    (wd_sel),
        .alub_sel  (alub_sel),
        .alu_op    (alu_op),
        .legal     (legal),
        .is_mem    (is_mem),
        .is_store  (is_store),
        .rf_wr     (rf_wr)
    );

`ifndef MCTRL_ILL_INST_EN
    logic unused_legal;
    assign unused_legal = legal;
`endif

    assign wait_last = (wait_cnt == 8'(WAIT_MAX - 1));

    always_comb begin
        nxt_state  = cur_state;
        err_nxt    = err_q;
        imem_req_c = 1'b0;
        dram_req_c = 1'b0;
        ir_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        rf_we_c    = DISABLE;
        dram_we_c  = READ;
        case (cur_state)
            ST_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ack) begin
                    ir_we_c   = 1'b1;
                    nxt_state = ST_DECODE;
                end else if (wait_last) begin
                    nxt_state = ST_HALT;
                    err_nxt   = ERR_IMEM;
                end
            end
            ST_DECODE: begin
`ifdef MCTRL_ILL_INST_EN
                if (!legal) begin
                    nxt_state = ST_HALT;
                    err_nxt   = ERR_ILL;
                end else begin
                    nxt_state = ST_EXEC;
                end
`else
                nxt_state = ST_EXEC;
`endif
            end
            ST_EXEC: nxt_state = is_mem ? ST_MEM : ST_WB;
            ST_MEM: begin
                dram_req_c = 1'b1;
                dram_we_c  = is_store ? WRITE : READ;
                if (dram_ack) begin
                    nxt_state = ST_WB;
                end else if (wait_last) begin
                    nxt_state = ST_HALT;
                    err_nxt   = ERR_DRAM;
                end
            end
            ST_WB: begin
                pc_we_c   = 1'b1;
                rf_we_c   = rf_wr ? ENABLE : DISABLE;
                nxt_state = ST_FETCH;
            end
            ST_HALT: nxt_state = ST_HALT;
            default: nxt_state = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state <= ST_FETCH;
            wait_cnt  <= 8'd0;
            flag_zero <= 1'b0;
            flag_sgn  <= 1'b0;
            err_q     <= ERR_NONE;
        end else begin
            cur_state <= nxt_state;
            err_q     <= err_nxt;
            if (nxt_state != cur_state)
                wait_cnt <= 8'd0;
            else if ((imem_req_c && !imem_ack) || (dram_req_c && !dram_ack))
                wait_cnt <= wait_cnt + 8'd1;
            if (cur_state == ST_EXEC) begin
                flag_zero <= zero;
                flag_sgn  <= sgn;
            end
        end
    end

    // Requests and strobes stay quiet for as long as reset is held, not just after its first edge.
    assign imem_req = imem_req_c & rst_n;
    assign dram_req = dram_req_c & rst_n;
    assign ir_we    = ir_we_c & rst_n;
    assign pc_we    = pc_we_c & rst_n;
    assign rf_we    = rf_we_c & rst_n;
    assign dram_we  = dram_we_c & rst_n;
    assign state    = cur_state;
    assign halt     = (cur_state == ST_HALT);
    assign err_code = err_q;

endmodule
